// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the seq_det_n serial pattern detector.
// seq_next() holds the full KMP-style transition rule for patterns up to MAX_LEN bits.
package seq_det_pkg;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned MAX_S_W = 5;

    function automatic int unsigned state_width(input int unsigned pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // Returns the longest pattern prefix that is a suffix of (matched prefix, b).
    function automatic logic [MAX_S_W-1:0] seq_next(
        input logic [MAX_S_W-1:0] s,
        input logic               b,
        input logic [MAX_LEN-1:0] pattern,
        input int unsigned        pat_len,
        input bit                 overlap
    );
        logic [MAX_LEN:0]   p;
        logic [MAX_LEN:0]   h;
        logic [MAX_LEN:0]   mask_s;
        logic [MAX_LEN:0]   mask_k;
        logic [MAX_LEN-1:0] tmp;
        logic [MAX_S_W-1:0] best;

        // p[i] is the i-th pattern bit in arrival order
        p = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (i < int'(pat_len)) begin
                tmp  = pattern >> (int'(pat_len) - 1 - i);
                p[i] = tmp[0];
            end
        end

        best = '0;
        if ((int'(s) == int'(pat_len)) && !overlap) begin
            best = (b == p[0]) ? MAX_S_W'(1) : MAX_S_W'(0);
        end else begin
            // h[j] is history bit j, oldest first; its length is s+1
            mask_s = ((MAX_LEN+1)'(1) << s) - (MAX_LEN+1)'(1);
            h      = (p & mask_s) | ((MAX_LEN+1)'(b) << s);
            for (int k = 1; k <= int'(MAX_LEN); k++) begin
                if ((k <= int'(s) + 1) && (k <= int'(pat_len))) begin
                    mask_k = ((MAX_LEN+1)'(1) << k) - (MAX_LEN+1)'(1);
                    if ((((h >> (int'(s) + 1 - k)) ^ p) & mask_k) == '0) begin
                        best = MAX_S_W'(k);
                    end
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_next.sv
// Combinational next-state evaluation for seq_det_n.
module seq_det_next
    import seq_det_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        S_W     = state_width(PAT_LEN)
) (
    input  logic [S_W-1:0] state,
    input  logic           in,
    output logic [S_W-1:0] next_state
);

    always_comb begin
        next_state = S_W'(seq_next(MAX_S_W'(state), in, MAX_LEN'(PATTERN), PAT_LEN, OVERLAP));
    end

endmodule

// File: rtl/seq_det_n.sv
// Parametrised serial sequence detector with Moore and Mealy match flags.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is zero.
module seq_det_n
    import seq_det_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int unsigned        CNT_W   = 8,
    parameter int unsigned        S_W     = state_width(PAT_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    output logic             z_moore,
    output logic             z_mealy,
    output logic [S_W-1:0]   out_state,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [S_W-1:0] FULL = S_W'(PAT_LEN);

    logic [S_W-1:0] state_q;
    logic [S_W-1:0] state_d;
    logic [S_W-1:0] next_state;
    logic           moore_q;
    logic           hit;

    seq_det_next #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP),
        .S_W     (S_W)
    ) u_next (
        .state      (state_q),
        .in         (in),
        .next_state (next_state)
    );

    always_comb begin
        hit     = en && (next_state == FULL);
        state_d = en ? next_state : state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            moore_q <= 1'b0;
        end else begin
            state_q <= state_d;
            moore_q <= (state_d == FULL);
        end
    end

    assign out_state = state_q;
    assign z_moore   = moore_q;
    assign z_mealy   = hit;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: doc/seq_det_n.md
# seq_det_n

Parametrised serial sequence detector. It samples one input bit per clock and flags every occurrence of a compile-time pattern of up to 16 bits. It provides both a Moore flag and a Mealy flag, a selectable overlapping or non-overlapping match mode, and an optional saturating match counter. It sits at the same level as the existing fixed 2-bit-state two-output detectors and supersedes them for new lab designs.

## Interface
- PAT_LEN, 4: pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011: pattern value; the MSB is received first. Only the low PAT_LEN bits are used.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = matching restarts from empty after each hit.
- CNT_W, 8: width of match_cnt.
- S_W, $clog2(PAT_LEN+1): state width. Derived; do not override.
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- en  in  1  sample enable; when low, `in` is ignored and all registers hold.
- in  in  1  serial data bit.
- z_moore  out  1  registered; high while out_state == PAT_LEN.
- z_mealy  out  1  combinational; high when the current bit completes the pattern (en=1 and next state == PAT_LEN).
- out_state  out  S_W  current state = number of pattern bits currently matched (0..PAT_LEN).
- match_cnt  out  CNT_W  number of completed matches (see Configuration).

## Operation
- Notation: P[i] is pattern bit i in arrival order, so P[0] = PATTERN[PAT_LEN-1].
- State s is the length of the longest pattern prefix that equals a suffix of the accepted history.
- Next-state rule for s < PAT_LEN:
  - If in == P[s], next = s+1.
  - Otherwise, next = largest k ≤ s such that P[0..k-1] equals the last k bits of (P[0..s-1], in). This is the KMP fallback, not a reset to 0.
- Next-state rule for s == PAT_LEN:
  - OVERLAP=1: apply the fallback rule to (P[0..PAT_LEN-1], in).
  - OVERLAP=0: next = (in == P[0]) ? 1 : 0.
- en=0: next = s, z_mealy = 0, and the counter holds.
- Counter: increments by 1 on each clock edge where en=1 and next == PAT_LEN. It saturates at 2^CNT_W-1 and never wraps.
- Reset values: out_state=0, z_moore=0, z_mealy=0, match_cnt=0.

## Timing
- z_mealy rises in the same cycle in which the final pattern bit is presented on `in`. It is valid before the edge that samples that bit.
- z_moore and out_state==PAT_LEN follow one cycle later and are held for exactly one cycle per match, unless the next bit immediately completes another match. This is possible only with OVERLAP=1 and a pattern whose failure value is PAT_LEN-1, such as all-ones.
- Back-to-back matches produce back-to-back z_moore cycles with no gap.
- Reset asserted mid-pattern clears out_state, z_moore and match_cnt immediately, with no clock required. z_mealy drops combinationally.
- The first edge after rst deasserts samples normally.
- en toggling has no latency; the hold takes effect on the same edge.

## Configuration
- SEQ_DET_CNT_EN defined: the CNT_W-bit saturating counter is built and drives match_cnt.
- SEQ_DET_CNT_EN undefined: no counter flops are built and match_cnt is tied to all zeros. All other behaviour is identical.

## Structure
- Shared package seq_det_pkg holds:
  - the function seq_next(s, bit, PATTERN, PAT_LEN, OVERLAP), which implements the transition rule;
  - a localparam helper computing S_W.
- One combinational sub-module, seq_det_next, evaluates seq_next for the current state and `in`. The top module holds the state register, the z_moore register, the Mealy decode and the counter.

## Test plan
All scenarios use PATTERN=4'b1011 and PAT_LEN=4 unless stated.
- **Reset:** hold rst=0 for 2 cycles while driving `in` -> out_state=0, z_moore=0, z_mealy=0, match_cnt=0 throughout.
- **Single match:** en=1, feed 1,0,1,1 -> out_state steps 1,2,3,4; z_mealy high during the 4th bit; z_moore high the following cycle; match_cnt=1.
- **Overlap mode:** feed 1,0,1,1,0,1,1.
  - OVERLAP=1: two matches (bits 4 and 7), match_cnt=2.
  - OVERLAP=0: one match, out_state=0 after bit 5, match_cnt=1.
- **Fallback:** feed 1,0,1,0,1,1 -> states 1,2,3,2,3,4; one match, proving the fallback is not to 0.
- **Enable hold:** feed 1,0; drop en for 3 cycles while toggling `in`; raise en and feed 1,1 -> out_state holds at 2 during the hold, then a match, match_cnt=1.
- **Mid-pattern reset and saturation:**
  - Assert rst while out_state=3 -> out_state=0 asynchronously; a following `in`=1 gives state 1, not 4.
  - With CNT_W=2 and SEQ_DET_CNT_EN defined, 5 matches -> match_cnt=3.
  - Without the macro, match_cnt stays 0.
